binary_mul_seq_bi: RTL and testbench

// - Parametrised iterative binary multiplier; successor to the fixed 6x6 pipelined multiplier.
// - Per-transaction signed/unsigned mode, STEP multiplier bits retired per cycle.
// - Full-width product with no overflow; valid/ready handshakes on both sides.
// - Sits between operand sources and accumulators where area matters more than throughput.

---
 rtl/binary_mul_seq_bi.sv | 159 +++++++++++++++
 tb/tb_binary_mul_seq_bi.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/binary_mul_seq_bi.sv
// binary_mul_seq_bi
//   Iterative shift-and-add multiplier. Each transaction picks signed or
//   unsigned mode, and STEP multiplier bits are retired per clock. The
//   multiplication runs on magnitudes. The sign is applied once, on the
//   final sum, so the 2*WIDTH product never saturates or wraps.
//
// Parameters
//   WIDTH : operand width (>= 2)
//   STEP  : multiplier bits per cycle (1, 2 or 3). Must divide WIDTH.
//
// Ports
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   en          : global enable; when low, no register changes
//   in_valid    : operand handshake (input side)
//   in_ready    : operand handshake (output side)
//   sgn         : 1 = A/B are two's complement, 0 = unsigned
//   A, B        : multiplicand and multiplier (WIDTH bits)
//   out_valid   : product handshake (output side)
//   out_ready   : product handshake (input side)
//   P           : product (2*WIDTH bits), held until the next completion
module binary_mul_seq_bi #(
  parameter int WIDTH = 6,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = $clog2(N + 1);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Magnitude in WIDTH unsigned bits. The magnitude of -2^(WIDTH-1) is
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                           input logic s);
    return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  // Applies the captured sign to the unsigned product magnitude.
  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] m,
                                               input logic n);
    return n ? (~m + 1'b1) : m;
  endfunction

  state_t           state_q, state_d;
  logic [PW-1:0]    a_sh_q, a_sh_d;     // |A|, pre-shifted to the current step position
  logic [WIDTH-1:0] b_sh_q, b_sh_d;     // |B|; the low STEP bits are the next digit
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    p_q, p_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [PW-1:0]    partial;
  logic [PW-1:0]    sum;

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    // Digit is 0..2^STEP-1 with no recoding. The shifted partial product
    // always fits in PW bits.
    partial = a_sh_q * PW'(b_sh_q[STEP-1:0]);
    sum     = acc_q + partial;

    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_sh_d     = PW'(mag(A, sgn));
            b_sh_d     = mag(B, sgn);
            neg_d      = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc_d      = '0;
            cnt_d      = '0;
            in_ready_d = 1'b0;
            state_d    = S_BUSY;
          end
        end
        S_BUSY: begin
          acc_d  = sum;
          a_sh_d = a_sh_q << STEP;
          b_sh_d = b_sh_q >> STEP;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N - 1)) begin
            p_d         = apply_sign(sum, neg_q);
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
        S_DONE: begin
          // Draining only. A new in_valid is taken on a later edge, in IDLE.
          if (out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = S_IDLE;
          end
        end
        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign P         = p_q;

endmodule

// File: tb/tb_binary_mul_seq_bi.sv
module tb_binary_mul_seq_bi;

  logic clk = 1'b0;
  logic rst;
  logic en;

  logic        iv6, ir6, s6, ov6, or6;
  logic [5:0]  a6, b6;
  logic [11:0] p6;

  logic        iv8, ir8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  binary_mul_seq_bi #(.WIDTH(6), .STEP(1)) u6 (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(iv6), .in_ready(ir6), .sgn(s6), .A(a6), .B(b6),
    .out_valid(ov6), .out_ready(or6), .P(p6)
  );

  binary_mul_seq_bi #(.WIDTH(8), .STEP(2)) u8 (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(iv8), .in_ready(ir8), .sgn(s8), .A(a8), .B(b8),
    .out_valid(ov8), .out_ready(or8), .P(p8)
  );

  typedef struct {
    string  name;
    int     sel;       // 0 = 6x6 step1, 1 = 8x8 step2
    logic   s;
    longint a;
    longint b;
    longint exp_p;
    int     exp_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full transaction: accept, count edges to out_valid, drain.
  task automatic xact(input int sel, input logic s, input longint a,
                      input longint b, output longint p, output int lat);
    @(negedge clk);
    if (sel == 0) begin
      a6 = a[5:0]; b6 = b[5:0]; s6 = s; iv6 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; s8 = s; iv8 = 1'b1;
    end
    @(posedge clk); #1;
    iv6 = 1'b0; iv8 = 1'b0;
    lat = 0;
    while (!((sel == 0) ? ov6 : ov8) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (sel == 0) p = s ? longint'($signed(p6)) : longint'(p6);
    else          p = s ? longint'($signed(p8)) : longint'(p8);
    if (sel == 0) or6 = 1'b1; else or8 = 1'b1;
    @(posedge clk); #1;
    or6 = 1'b0; or8 = 1'b0;
  endtask

  longint p;
  int     lat;
  logic   stable_ok;

  initial begin
    vecs[0]  = '{"s6_m32xm32",  0, 1'b1, -32, -32, 1024,   6};
    vecs[1]  = '{"s6_m32x31",   0, 1'b1, -32,  31, -992,   6};
    vecs[2]  = '{"s6_31x31",    0, 1'b1,  31,  31, 961,    6};
    vecs[3]  = '{"u6_63x63",    0, 1'b0,  63,  63, 3969,   6};
    vecs[4]  = '{"u6_32x63",    0, 1'b0,  32,  63, 2016,   6};
    vecs[5]  = '{"s6_m1x1",     0, 1'b1,  -1,   1, -1,     6};
    vecs[6]  = '{"s6_0xm32",    0, 1'b1,   0, -32, 0,      6};
    vecs[7]  = '{"u8_255x255",  1, 1'b0, 255, 255, 65025,  4};
    vecs[8]  = '{"u8_0x200",    1, 1'b0,   0, 200, 0,      4};
    vecs[9]  = '{"s8_m128sq",   1, 1'b1, -128, -128, 16384, 4};
    vecs[10] = '{"s8_m128x127", 1, 1'b1, -128, 127, -16256, 4};
    vecs[11] = '{"s8_m3x100",   1, 1'b1,  -3, 100, -300,   4};
    vecs[12] = '{"u8_200x3",    1, 1'b0, 200,   3, 600,    4};

    rst = 1'b1; en = 1'b1;
    iv6 = 0; s6 = 0; a6 = 0; b6 = 0; or6 = 0;
    iv8 = 0; s8 = 0; a8 = 0; b8 = 0; or8 = 0;
    #12;
    check("rst_in_ready6",  ir6, 1);
    check("rst_out_valid6", ov6, 0);
    check("rst_p6",         p6,  0);
    check("rst_in_ready8",  ir8, 1);
    check("rst_out_valid8", ov8, 0);
    check("rst_p8",         p8,  0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      xact(vecs[i].sel, vecs[i].s, vecs[i].a, vecs[i].b, p, lat);
      check({vecs[i].name, "_p"},   p,   vecs[i].exp_p);
      check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
    end

    // Exhaustive signed 6x6
    for (int a = -32; a < 32; a++) begin
      for (int b = -32; b < 32; b++) begin
        xact(0, 1'b1, longint'(a), longint'(b), p, lat);
        check($sformatf("exh_p_%0d_%0d", a, b), p, longint'(a * b));
        check($sformatf("exh_lat_%0d_%0d", a, b), lat, 6);
      end
    end

    // Backpressure: 5 * -3, hold out_ready low for 10 cycles while new operands are offered
    @(negedge clk);
    a6 = 6'd5; b6 = 6'(-3); s6 = 1'b1; iv6 = 1'b1;
    @(posedge clk); #1;
    a6 = 6'd2; b6 = 6'd3;          // new operands, still valid
    lat = 0;
    while (!ov6 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("bp_lat", lat, 6);
    stable_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ov6 !== 1'b1 || ir6 !== 1'b0 || $signed(p6) !== -12'sd15) stable_ok = 1'b0;
    end
    check("bp_stable", stable_ok, 1);
    or6 = 1'b1;                    // in_valid still high: drain only
    @(posedge clk); #1;
    or6 = 1'b0;
    check("bp_drain_ov", ov6, 0);
    check("bp_drain_ir", ir6, 1);
    check("bp_p_held",   $signed(p6), -15);
    @(posedge clk); #1;            // accept 2*3 in IDLE
    iv6 = 1'b0;
    check("bp_accept_ir", ir6, 0);
    lat = 0;
    while (!ov6 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("bp_next_lat", lat, 6);
    check("bp_next_p",   $signed(p6), 6);
    or6 = 1'b1; @(posedge clk); #1; or6 = 1'b0;

    // en low for 3 cycles mid-BUSY: -7 * 9
    @(negedge clk);
    a6 = 6'(-7); b6 = 6'd9; s6 = 1'b1; iv6 = 1'b1;
    @(posedge clk); #1;
    iv6 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    en = 1'b0;
    lat = 2;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; lat++; end
    check("en_frozen_ov", ov6, 0);
    en = 1'b1;
    while (!ov6 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("en_lat", lat, 9);
    check("en_p",   $signed(p6), -63);
    or6 = 1'b1; @(posedge clk); #1; or6 = 1'b0;

    // Reset 2 cycles after accept: 7 * 7 aborted
    @(negedge clk);
    a6 = 6'd7; b6 = 6'd7; s6 = 1'b1; iv6 = 1'b1;
    @(posedge clk); #1;
    iv6 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_ov", ov6, 0);
    check("arst_ir", ir6, 1);
    check("arst_p",  p6,  0);
    @(negedge clk); rst = 1'b0;
    stable_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ov6 !== 1'b0 || p6 !== 12'd0) stable_ok = 1'b0;
    end
    check("arst_no_stale", stable_ok, 1);
    xact(0, 1'b1, -5, 6, p, lat);
    check("arst_after_p",   p,   -30);
    check("arst_after_lat", lat, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
